// File: rtl/sync_updown_srff_counter.sv
// sync_updown_srff_counter: modulo-N up/down counter whose state bits are
// modelled as SR flip-flops. A target value d is chosen (reset > load > en >
// hold) and converted into per-bit set/reset excitation; the register then
// applies q = s | (~r & q) on each rising edge.
//
// Build option: define SYNC_UPDOWN_SRFF_SATURATE_EN to make the counter stop
// at MODULUS-1 (counting up) and 0 (counting down) instead of wrapping.
// Terminal count is the same in both builds; wrap never pulses when saturating.

module sync_updown_srff_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] s_vec,
  output logic [WIDTH-1:0] r_vec
);

  // Largest legal count; fits WIDTH bits because MODULUS <= 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] tgt;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_top;
  logic             at_bot;

  // Target selection, SR excitation and terminal count.
  always_comb begin
    at_top = (cnt_q == MAX_VAL);
    at_bot = (cnt_q == '0);
    tgt    = cnt_q;
    wrap_d = 1'b0;

    if (load) begin
      // Out-of-range load values clamp to the top of the count range.
      tgt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
`ifdef SYNC_UPDOWN_SRFF_SATURATE_EN
          tgt = cnt_q;
`else
          tgt    = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          tgt = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
`ifdef SYNC_UPDOWN_SRFF_SATURATE_EN
          tgt = cnt_q;
`else
          tgt    = MAX_VAL;
          wrap_d = 1'b1;
`endif
        end else begin
          tgt = cnt_q - WIDTH'(1);
        end
      end
    end

    // Set only bits that must rise, reset only bits that must fall: never both.
    s_vec = tgt & ~cnt_q;
    r_vec = ~tgt & cnt_q;
    cnt_d = s_vec | (~r_vec & cnt_q);

    tc = up_dn ? at_top : at_bot;
  end

  // State register; reset overrides any pending excitation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_srff_counter.sv
// Directed bench for sync_updown_srff_counter: three instances with different
// WIDTH/MODULUS share the control inputs; each scenario checks one instance.

module tb_sync_updown_srff_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [1:0] lv2;
  logic [3:0] lv10;
  logic [2:0] lv8;

  logic [1:0] q2, s2, r2;
  logic       tc2, w2;
  logic [3:0] q10, s10, r10;
  logic       tc10, w10;
  logic [2:0] q8, s8, r8;
  logic       tc8, w8;

  int errors = 0;
  int checks = 0;

  int e31_q[5] = '{3, 2, 1, 0, 3};
  int e31_w[5] = '{1, 0, 0, 0, 1};
`ifdef SYNC_UPDOWN_SRFF_SATURATE_EN
  int e35_q[3] = '{7, 7, 7};
  int e35_w[3] = '{0, 0, 0};
  localparam int E35_R  = 0;
  localparam int E35_DN = 6;
`else
  int e35_q[3] = '{0, 1, 2};
  int e35_w[3] = '{1, 0, 0};
  localparam int E35_R  = 7;
  localparam int E35_DN = 1;
`endif

  sync_updown_srff_counter #(.WIDTH(2), .MODULUS(4)) u2 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv2), .q(q2), .tc(tc2), .wrap(w2), .s_vec(s2), .r_vec(r2));

  sync_updown_srff_counter #(.WIDTH(4), .MODULUS(10)) u10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv10), .q(q10), .tc(tc10), .wrap(w10), .s_vec(s10), .r_vec(r10));

  sync_updown_srff_counter #(.WIDTH(3), .MODULUS(8)) u8 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv8), .q(q8), .tc(tc8), .wrap(w8), .s_vec(s8), .r_vec(r8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Excitation exclusivity and range invariants on every cycle.
  always @(negedge clk) begin
    chk("inv_sr2",  32'(s2 & r2), 0);
    chk("inv_sr10", 32'(s10 & r10), 0);
    chk("inv_sr8",  32'(s8 & r8), 0);
    chk("inv_rng2",  32'(32'(q2) < 4), 1);
    chk("inv_rng10", 32'(32'(q10) < 10), 1);
  end

  initial begin
    // Reset with a pending load: register cleared, excitation shows load target.
    reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b1;
    lv2 = 2'd0; lv10 = 4'd5; lv8 = 3'd0;
    tick();
    chk("rst_q2", 32'(q2), 0);
    chk("rst_w2", 32'(w2), 0);
    chk("rst_q10", 32'(q10), 0);
    chk("rst_w10", 32'(w10), 0);
    chk("rst_q8", 32'(q8), 0);
    chk("rst_s10", 32'(s10), 5);
    chk("rst_r10", 32'(r10), 0);
    chk("rst_tc2", 32'(tc2), 1);

    // WIDTH=2 MODULUS=4 counting down through the wrap.
    reset = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    chk("dn_s2_pre", 32'(s2), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("dn_q2_%0d", i), 32'(q2), e31_q[i]);
      chk($sformatf("dn_w2_%0d", i), 32'(w2), e31_w[i]);
      chk($sformatf("dn_tc2_%0d", i), 32'(tc2), (e31_q[i] == 0) ? 1 : 0);
    end
    chk("dn_s2", 32'(s2), 0);
    chk("dn_r2", 32'(r2), 1);

    // Terminal count independent of enable; hold leaves excitation idle.
    en = 1'b0; up_dn = 1'b1;
    #1;
    chk("hold_tc2", 32'(tc2), 1);
    chk("hold_s2", 32'(s2), 0);
    chk("hold_r2", 32'(r2), 0);
    tick();
    chk("hold_q2", 32'(q2), 3);
    chk("hold_w2", 32'(w2), 0);

    // MODULUS=10: load 8 then count up across the wrap.
    load = 1'b1; lv10 = 4'd8;
    tick();
    chk("ld8_q10", 32'(q10), 8);
    chk("ld8_w10", 32'(w10), 0);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1;
    chk("up_tc10_8", 32'(tc10), 0);
    tick();
    chk("up_q10_9", 32'(q10), 9);
    chk("up_w10_9", 32'(w10), 0);
    chk("up_tc10_9", 32'(tc10), 1);
    tick();
    chk("up_q10_0", 32'(q10), 0);
    chk("up_w10_0", 32'(w10), 1);
    chk("up_tc10_0", 32'(tc10), 0);
    tick();
    chk("up_q10_1", 32'(q10), 1);
    chk("up_w10_1", 32'(w10), 0);

    // Out-of-range load clamps and beats enable; no wrap on a load at terminal count.
    load = 1'b1; lv10 = 4'd13;
    tick();
    chk("clamp_q10", 32'(q10), 9);
    chk("clamp_w10", 32'(w10), 0);
    tick();
    chk("ldtc_q10", 32'(q10), 9);
    chk("ldtc_w10", 32'(w10), 0);
    chk("ldtc_s10", 32'(s10), 0);
    chk("ldtc_r10", 32'(r10), 0);
    chk("ldtc_tc10", 32'(tc10), 1);

    // load_val == MODULUS is the first clamped value.
    lv10 = 4'd2;
    tick();
    chk("ld2_q10", 32'(q10), 2);
    lv10 = 4'd10;
    #1;
    chk("ld10_s10", 32'(s10), 9);
    chk("ld10_r10", 32'(r10), 2);
    tick();
    chk("ld10_q10", 32'(q10), 9);

    // Reset mid-count overrides load; counting resumes from 0.
    lv10 = 4'd5;
    tick();
    load = 1'b0;
    tick();
    chk("mid_q10", 32'(q10), 6);
    reset = 1'b1; load = 1'b1; lv10 = 4'd3;
    tick();
    chk("mrst_q10", 32'(q10), 0);
    chk("mrst_w10", 32'(w10), 0);
    chk("mrst_s10", 32'(s10), 3);
    reset = 1'b0; load = 1'b0;
    tick();
    chk("resume_q10", 32'(q10), 1);

    // Count down through 0, then reverse direction on the next edge.
    up_dn = 1'b0;
    #1;
    chk("dn10_tc_1", 32'(tc10), 0);
    tick();
    chk("dn10_q0", 32'(q10), 0);
    chk("dn10_w0", 32'(w10), 0);
    chk("dn10_tc0", 32'(tc10), 1);
    tick();
    chk("dn10_q9", 32'(q10), 9);
    chk("dn10_w9", 32'(w10), 1);
    chk("dn10_tc9", 32'(tc10), 0);
    up_dn = 1'b1;
    tick();
    chk("rev_q10", 32'(q10), 0);
    chk("rev_w10", 32'(w10), 1);

    // WIDTH=3 MODULUS=8 at the top: saturates or wraps depending on the build.
    load = 1'b1; en = 1'b0; lv8 = 3'd7;
    tick();
    chk("ld7_q8", 32'(q8), 7);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1;
    chk("top_tc8", 32'(tc8), 1);
    chk("top_s8", 32'(s8), 0);
    chk("top_r8", 32'(r8), E35_R);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("top_q8_%0d", i), 32'(q8), e35_q[i]);
      chk($sformatf("top_w8_%0d", i), 32'(w8), e35_w[i]);
    end
    up_dn = 1'b0;
    tick();
    chk("top_dn_q8", 32'(q8), E35_DN);
    chk("top_dn_w8", 32'(w8), 0);

    en = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_updown_srff_counter.md
SYNC_UPDOWN_SRFF_COUNTER -- requirements
Module: sync_updown_srff_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, WIDTH >= 2.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  count enable.
REQ-006 Port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 Port load  input  1  synchronous parallel load request.
REQ-008 Port load_val  input  WIDTH  value to load.
REQ-009 Port q  output  WIDTH  registered count value.
REQ-010 Port tc  output  1  terminal count, combinational.
REQ-011 Port wrap  output  1  registered one-cycle pulse, count wrapped on the previous edge.
REQ-012 Port s_vec  output  WIDTH  per-bit SR set excitation applied at the next edge, combinational.
REQ-013 Port r_vec  output  WIDTH  per-bit SR reset excitation applied at the next edge, combinational.

Function
REQ-014 Each bit of q SHALL be an SR flip-flop: q[i] next = s_vec[i] | (~r_vec[i] & q[i]).
REQ-015 Excitation SHALL derive from target value d: s_vec = d & ~q, r_vec = ~d & q; s_vec & r_vec SHALL be zero in every cycle.
REQ-016 Priority SHALL be reset > load > en > hold.
REQ-017 load=1: d = load_val if load_val < MODULUS, else d = MODULUS-1 (clamp); en and up_dn ignored.
REQ-018 en=1, load=0, up_dn=1: d = q+1, or 0 when q = MODULUS-1.
REQ-019 en=1, load=0, up_dn=0: d = q-1, or MODULUS-1 when q = 0.
REQ-020 en=0, load=0: d = q; s_vec and r_vec SHALL be all zero.
REQ-021 Count latency SHALL be one clock: q reflects d on the edge after inputs are sampled.
REQ-022 tc SHALL be 1 when (up_dn=1 and q=MODULUS-1) or (up_dn=0 and q=0), independent of en.
REQ-023 wrap SHALL be 1 for exactly the cycle following an edge where en=1, load=0, tc=1 and the counter wrapped; 0 otherwise, including for loads.
REQ-024 A direction change SHALL take effect on the same edge it is sampled; no idle cycle.
REQ-025 q SHALL never hold a value >= MODULUS.

Reset
REQ-026 On a rising edge with reset=1, q SHALL become 0 and wrap SHALL become 0, overriding load and en.
REQ-027 Reset asserted mid-count SHALL clear state on that edge; counting SHALL resume from 0 on the first edge after reset deasserts.
REQ-028 s_vec/r_vec SHALL reflect the load/count/hold target during reset; the registered update SHALL be suppressed by reset.

Configuration
REQ-029 Macro SYNC_UPDOWN_SRFF_SATURATE_EN: when defined, the counter SHALL saturate: up at MODULUS-1 and down at 0 give d = q, s_vec = r_vec = 0, wrap held at 0.
REQ-030 When SYNC_UPDOWN_SRFF_SATURATE_EN is undefined, wrap-around per REQ-018/019/023 SHALL apply; tc behaviour is identical in both builds.

Verification
REQ-031 WIDTH=2, MODULUS=4, reset then en=1, up_dn=0 for 5 edges -> q = 0,3,2,1,0,3; wrap=1 the cycle after 0->3 edges only.
REQ-032 WIDTH=4, MODULUS=10, load_val=8, then up 3 edges -> q = 8,9,0,1; tc=1 while q=9; wrap=1 the cycle q=0.
REQ-033 WIDTH=4, MODULUS=10, load=1, load_val=13, en=1 same cycle -> q = 9, wrap=0; load wins over en.
REQ-034 Count up from q=5, assert reset for one edge with load=1 -> q = 0, wrap=0; next edge up -> q = 1.
REQ-035 SATURATE_EN defined, WIDTH=3, MODULUS=8, q=7, up 3 edges -> q stays 7, wrap=0, s_vec=r_vec=0; down 1 edge -> q = 6.
REQ-036 All scenarios: assertion that s_vec & r_vec == 0 every cycle and q < MODULUS every cycle.
